// File: rtl/ddr3_app_traffic_gen_if.sv
// MIG 7-series user (app) interface: command, write-data and read-data channels.
// A command transfers on a rising edge with app_en && app_rdy, a write beat with
// app_wdf_wren && app_wdf_rdy; the initiator holds valid and payload stable until that
// edge. app_rd_data_valid has no back-pressure and returns data in command order.
interface ddr3_app_traffic_gen_if;
   logic [29:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy;
   logic [255:0] app_wdf_data;
   logic [31:0]  app_wdf_mask;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic         app_wdf_rdy;
   logic [255:0] app_rd_data;
   logic         app_rd_data_valid;

   modport master (
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );

   modport slave (
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
   );
endinterface

// File: rtl/ddr3_app_traffic_gen.sv
// DDR3 app-interface traffic generator: writes a counting pattern to NUM_BURSTS bursts,
// reads them back and compares. Define DDR3_TG_TIMEOUT_EN to add a read-phase watchdog.
module ddr3_app_traffic_gen #(
   parameter int          NUM_BURSTS     = 256,
   parameter logic [29:0] BASE_ADDR      = 30'h0,
   parameter int          ADDR_STEP      = 8,
   parameter logic [31:0] PATTERN_SEED   = 32'hA5A5_0000,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic                          ui_clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          init_calib_complete,
   ddr3_app_traffic_gen_if.master        app,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [15:0]                   err_count,
   output logic [29:0]                   first_err_addr,
   output logic                          timeout,
   output logic [2:0]                    dbg_state
);
   localparam int            CW   = $clog2(NUM_BURSTS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BURSTS);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_CALIB = 3'd1,
      S_WRITE      = 3'd2,
      S_READ       = 3'd3,
      S_DONE       = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] wc_q, wc_d, wd_q, wd_d, rc_q, rc_d, rd_q, rd_d;
   logic [15:0]   err_q, err_d;
   logic [29:0]   ferr_q, ferr_d;
   logic          abort_q, abort_d;
   logic          cmd_en, cmd_rd, wdf_en;
   logic          start_run, rd_beat, to_fire;

   function automatic logic [29:0] addr_of(input logic [CW-1:0] idx);
      return BASE_ADDR + 30'(idx) * 30'(ADDR_STEP);
   endfunction

   function automatic logic [255:0] pattern_of(input logic [CW-1:0] idx);
      logic [31:0]  base;
      logic [255:0] p;
      p    = '0;
      base = PATTERN_SEED + (32'(idx) << 3);
      for (int k = 0; k < 8; k++) p[k*32 +: 32] = base + 32'(k);
      return p;
   endfunction

   always_ff @(posedge ui_clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = init_calib_complete ? S_WRITE : S_WAIT_CALIB;
         S_WAIT_CALIB:   if (init_calib_complete) state_d = S_WRITE;
         S_WRITE: begin
            if (!init_calib_complete)             state_d = S_DONE;
            else if (wc_d == LAST && wd_d == LAST) state_d = S_READ;
         end
         S_READ: if (!init_calib_complete || to_fire || rd_d == LAST) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Valids depend only on registered state and counters, never on the ready inputs.
   always_comb begin
      cmd_en = 1'b0;
      cmd_rd = 1'b0;
      wdf_en = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state_q)
         S_WAIT_CALIB: busy = 1'b1;
         S_WRITE: begin
            busy   = 1'b1;
            cmd_en = (wc_q != LAST);
            wdf_en = (wd_q != LAST);
         end
         S_READ: begin
            busy   = 1'b1;
            cmd_en = (rc_q != LAST);
            cmd_rd = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign app.app_en       = cmd_en;
   assign app.app_cmd      = {2'b00, cmd_en & cmd_rd};
   assign app.app_addr     = cmd_en ? addr_of(cmd_rd ? rc_q : wc_q) : 30'h0;
   assign app.app_wdf_wren = wdf_en;
   assign app.app_wdf_end  = wdf_en;
   assign app.app_wdf_data = wdf_en ? pattern_of(wd_q) : 256'h0;
   assign app.app_wdf_mask = 32'h0;

   assign start_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
   assign rd_beat   = (state_q == S_READ) && app.app_rd_data_valid;

   always_comb begin
      wc_d    = wc_q;
      wd_d    = wd_q;
      rc_d    = rc_q;
      rd_d    = rd_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      abort_d = abort_q;
      if (start_run) begin
         wc_d    = '0;
         wd_d    = '0;
         rc_d    = '0;
         rd_d    = '0;
         err_d   = '0;
         ferr_d  = '0;
         abort_d = 1'b0;
      end else begin
         if (state_q == S_WRITE && cmd_en && app.app_rdy) wc_d = wc_q + CW'(1);
         if (wdf_en && app.app_wdf_rdy)                   wd_d = wd_q + CW'(1);
         if (state_q == S_READ && cmd_en && app.app_rdy)  rc_d = rc_q + CW'(1);
         if (rd_beat) begin
            rd_d = rd_q + CW'(1);
            if (app.app_rd_data != pattern_of(rd_q)) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (err_q == 16'h0)    ferr_d = addr_of(rd_q);
            end
         end
         if ((state_q == S_WRITE || state_q == S_READ) && !init_calib_complete) abort_d = 1'b1;
      end
   end

   always_ff @(posedge ui_clk or negedge reset) begin
      if (!reset) begin
         wc_q    <= '0;
         wd_q    <= '0;
         rc_q    <= '0;
         rd_q    <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         wc_q    <= wc_d;
         wd_q    <= wd_d;
         rc_q    <= rc_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         abort_q <= abort_d;
      end
   end

`ifdef DDR3_TG_TIMEOUT_EN
   // Counts READ cycles since the last returned beat.
   logic [31:0] to_cnt_q;
   logic        to_q;
   assign to_fire = (state_q == S_READ) && (to_cnt_q == 32'(TIMEOUT_CYCLES));
   always_ff @(posedge ui_clk or negedge reset) begin
      if (!reset) begin
         to_cnt_q <= '0;
         to_q     <= 1'b0;
      end else begin
         if (state_q != S_READ || app.app_rd_data_valid) to_cnt_q <= '0;
         else                                            to_cnt_q <= to_cnt_q + 32'd1;
         if (start_run)    to_q <= 1'b0;
         else if (to_fire) to_q <= 1'b1;
      end
   end
   assign timeout = to_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign to_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   assign pass           = done && (err_q == 16'h0) && !abort_q && !timeout;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign dbg_state      = state_q;
endmodule

// File: tb/tb_ddr3_app_traffic_gen.sv
// Bench for ddr3_app_traffic_gen: memory-model responder plus a scoreboard of expected
// write/read commands and write data; covers calibration wait, stalls, corruption and reset.
`timescale 1ns/1ps
module tb_ddr3_app_traffic_gen;
   localparam int          NB   = 4;
   localparam int          TO   = 100;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic        ui_clk = 1'b0;
   logic        reset, start, init_calib_complete;
   logic        busy, done, pass, timeout;
   logic [15:0] err_count;
   logic [29:0] first_err_addr;
   logic [2:0]  dbg_state;

   ddr3_app_traffic_gen_if app_if();

   ddr3_app_traffic_gen #(
      .NUM_BURSTS(NB), .BASE_ADDR(30'h0), .ADDR_STEP(8),
      .PATTERN_SEED(SEED), .TIMEOUT_CYCLES(TO)
   ) dut (
      .ui_clk(ui_clk), .reset(reset), .start(start), .init_calib_complete(init_calib_complete),
      .app(app_if), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .timeout(timeout), .dbg_state(dbg_state)
   );

   always #5 ui_clk = ~ui_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] model_addr(input int i);
      return 30'(i * 8);
   endfunction

   function automatic logic [255:0] model_data(input int i);
      logic [255:0] p;
      for (int k = 0; k < 8; k++) p[k*32 +: 32] = SEED + 32'(i * 8 + k);
      return p;
   endfunction

   // Scoreboard expectations and responder state
   logic [29:0]  exp_waddr_q[$];
   logic [255:0] exp_wdata_q[$];
   logic [29:0]  exp_raddr_q[$];
   logic [29:0]  wa_q[$];
   logic [255:0] wdat_q[$];
   logic [29:0]  rpend_q[$];
   int           rdue_q[$];
   logic [255:0] mem [logic [29:0]];
   int  cyc = 0;
   bit  rand_mode = 0;
   int  corrupt_idx = -1, drop_idx = -1;
   int  n_wcmd, n_wdata, n_rcmd, n_rret, rret_idx;
   int  last_valid_cyc = 0, done_cyc = 0;

   task automatic load_expect();
      exp_waddr_q.delete();
      exp_wdata_q.delete();
      exp_raddr_q.delete();
      for (int i = 0; i < NB; i++) begin
         exp_waddr_q.push_back(model_addr(i));
         exp_wdata_q.push_back(model_data(i));
         exp_raddr_q.push_back(model_addr(i));
      end
      n_wcmd = 0; n_wdata = 0; n_rcmd = 0; n_rret = 0; rret_idx = 0;
   endtask

   initial begin : responder
      logic         hold_cmd, hold_wdf;
      logic [29:0]  held_addr, a;
      logic [2:0]   held_cmd;
      logic [255:0] held_data, d;
      hold_cmd = 0; hold_wdf = 0; held_addr = '0; held_cmd = '0; held_data = '0;
      app_if.app_rdy = 1'b1;
      app_if.app_wdf_rdy = 1'b1;
      app_if.app_rd_data = '0;
      app_if.app_rd_data_valid = 1'b0;
      forever begin
         @(negedge ui_clk);
         if (!reset) begin
            wa_q.delete(); wdat_q.delete(); rpend_q.delete(); rdue_q.delete();
            exp_waddr_q.delete(); exp_wdata_q.delete(); exp_raddr_q.delete();
            hold_cmd = 0; hold_wdf = 0;
         end else begin
            if (hold_cmd)
               check_eq("cmd_hold", {app_if.app_en, app_if.app_cmd, app_if.app_addr},
                        {1'b1, held_cmd, held_addr});
            if (hold_wdf) begin
               check_eq("wdf_hold_valid", app_if.app_wdf_wren, 1'b1);
               check_eq("wdf_hold_data", app_if.app_wdf_data, held_data);
            end
            hold_cmd  = app_if.app_en && !app_if.app_rdy;
            held_addr = app_if.app_addr;
            held_cmd  = app_if.app_cmd;
            hold_wdf  = app_if.app_wdf_wren && !app_if.app_wdf_rdy;
            held_data = app_if.app_wdf_data;
            if (app_if.app_en && app_if.app_rdy) begin
               if (app_if.app_cmd == 3'b000) begin
                  n_wcmd++;
                  if (exp_waddr_q.size() > 0) check_eq("wcmd_addr", app_if.app_addr, exp_waddr_q.pop_front());
                  wa_q.push_back(app_if.app_addr);
               end else begin
                  n_rcmd++;
                  check_eq("rcmd_code", app_if.app_cmd, 3'b001);
                  if (exp_raddr_q.size() > 0) check_eq("rcmd_addr", app_if.app_addr, exp_raddr_q.pop_front());
                  rpend_q.push_back(app_if.app_addr);
                  rdue_q.push_back(cyc + 4);
               end
            end
            if (app_if.app_wdf_wren && app_if.app_wdf_rdy) begin
               n_wdata++;
               check_eq("wdf_end_mask", {app_if.app_wdf_end, app_if.app_wdf_mask}, {1'b1, 32'h0});
               if (exp_wdata_q.size() > 0) check_eq("wdf_data", app_if.app_wdf_data, exp_wdata_q.pop_front());
               wdat_q.push_back(app_if.app_wdf_data);
            end
            while (wa_q.size() > 0 && wdat_q.size() > 0) mem[wa_q.pop_front()] = wdat_q.pop_front();
         end
         @(posedge ui_clk);
         cyc++;
         #1;
         app_if.app_rdy     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         app_if.app_wdf_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         app_if.app_rd_data_valid = 1'b0;
         app_if.app_rd_data = '0;
         if (reset && rdue_q.size() > 0 && rdue_q[0] <= cyc) begin
            void'(rdue_q.pop_front());
            a = rpend_q.pop_front();
            if (rret_idx != drop_idx) begin
               d = mem.exists(a) ? mem[a] : '0;
               if (rret_idx == corrupt_idx) d[0] = ~d[0];
               app_if.app_rd_data = d;
               app_if.app_rd_data_valid = 1'b1;
               n_rret++;
               last_valid_cyc = cyc;
            end
            rret_idx++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge ui_clk); #1 start = 1'b1;
      @(posedge ui_clk); #1 start = 1'b0;
   endtask

   task automatic finish_run(input string tag, input logic [15:0] e_err, input logic [29:0] e_first,
                             input logic e_pass, input int e_rret, input logic e_to);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge ui_clk);
         if (done) begin ok = 1; break; end
      end
      done_cyc = cyc;
      check_eq({tag, "_done"}, ok, 1'b1);
      check_eq({tag, "_pass"}, pass, e_pass);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_err_count"}, err_count, e_err);
      check_eq({tag, "_first_err"}, first_err_addr, e_first);
      check_eq({tag, "_timeout"}, timeout, e_to);
      check_eq({tag, "_n_wcmd"}, 32'(n_wcmd), 32'(NB));
      check_eq({tag, "_n_wdata"}, 32'(n_wdata), 32'(NB));
      check_eq({tag, "_n_rcmd"}, 32'(n_rcmd), 32'(NB));
      check_eq({tag, "_n_rret"}, 32'(n_rret), 32'(e_rret));
      check_eq({tag, "_exp_left"}, 32'(exp_waddr_q.size() + exp_wdata_q.size() + exp_raddr_q.size()), 32'd0);
   endtask

   task automatic do_run(input string tag, input logic [15:0] e_err, input logic [29:0] e_first,
                         input logic e_pass, input int e_rret, input logic e_to);
      load_expect();
      pulse_start();
      finish_run(tag, e_err, e_first, e_pass, e_rret, e_to);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  bad;
      bit  ok;
      reset = 1'b0; start = 1'b0; init_calib_complete = 1'b1;
      repeat (3) @(negedge ui_clk);
      check_eq("rst_status", {busy, done, pass, timeout}, 4'b0000);
      check_eq("rst_err", {err_count, first_err_addr}, 46'h0);
      check_eq("rst_app", {app_if.app_en, app_if.app_wdf_wren, app_if.app_addr}, 32'h0);
      check_eq("rst_state", dbg_state, 3'd0);
      #2 reset = 1'b1;

      do_run("ideal", 16'd0, 30'd0, 1'b1, NB, 1'b0);

      // Calibration not yet complete: hold off for 50 cycles
      init_calib_complete = 1'b0;
      load_expect();
      pulse_start();
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ui_clk);
         if (!busy || app_if.app_en || app_if.app_wdf_wren) bad++;
      end
      check_eq("calib_wait_bad_cycles", 32'(bad), 32'd0);
      @(posedge ui_clk); #1 init_calib_complete = 1'b1;
      @(negedge ui_clk);
      check_eq("calib_rise_no_cmd", app_if.app_en, 1'b0);
      @(negedge ui_clk);
      check_eq("calib_first_cmd", {app_if.app_en, app_if.app_cmd, app_if.app_addr}, {1'b1, 3'b000, 30'h0});
      finish_run("calib", 16'd0, 30'd0, 1'b1, NB, 1'b0);

      rand_mode = 1;
      do_run("random_rdy", 16'd0, 30'd0, 1'b1, NB, 1'b0);
      rand_mode = 0;

      corrupt_idx = 2;
      do_run("corrupt", 16'd1, 30'd16, 1'b0, NB, 1'b0);
      corrupt_idx = -1;

      // Asynchronous reset in the middle of the read phase
      load_expect();
      pulse_start();
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge ui_clk);
         if (app_if.app_en && app_if.app_cmd == 3'b001) begin ok = 1; break; end
      end
      check_eq("mid_reach_read", ok, 1'b1);
      #2 reset = 1'b0;
      #1;
      check_eq("mid_rst_status", {busy, done, pass, timeout}, 4'b0000);
      check_eq("mid_rst_err", {err_count, first_err_addr}, 46'h0);
      check_eq("mid_rst_app", {app_if.app_en, app_if.app_wdf_wren, app_if.app_cmd, app_if.app_addr}, 35'h0);
      check_eq("mid_rst_wdata", app_if.app_wdf_data, 256'h0);
      repeat (3) @(negedge ui_clk);
      #2 reset = 1'b1;
      do_run("after_rst", 16'd0, 30'd0, 1'b1, NB, 1'b0);

`ifdef DDR3_TG_TIMEOUT_EN
      drop_idx = NB - 1;
      do_run("timeout", 16'd0, 30'd0, 1'b0, NB - 1, 1'b1);
      drop_idx = -1;
      check_eq("timeout_delay_in_range",
               ((done_cyc - last_valid_cyc) >= 95) && ((done_cyc - last_valid_cyc) <= 115), 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
